// File: rtl/checker_pkg.sv
// Shared definitions for the AND-gate checker: FSM state encoding,
// legal LATENCY range and the "no error recorded" index constant.
// Imported by and_gate_checker and exp_delay_line.
package checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;

  // Wide all-ones source; users slice it to their counter width.
  localparam logic [63:0] NO_ERR_ALL_ONES = {64{1'b1}};

endpackage

// File: rtl/exp_delay_line.sv
// LATENCY-deep shift register of {valid, exp, idx} entries that lines the
// expected AND result up with the gate output it must be compared against.
// Ports: clk/rst, push_* (stage 0 input, one entry per cycle), tail_* (oldest entry).
module exp_delay_line
  import checker_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int IDX_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic             push_exp,
  input  logic [IDX_W-1:0] push_idx,
  output logic             tail_vld,
  output logic             tail_exp,
  output logic [IDX_W-1:0] tail_idx
);

  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] exp_q;
  logic [IDX_W-1:0]   idx_q [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      exp_q <= '0;
      for (int i = 0; i < LATENCY; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= push_vld;
      exp_q[0] <= push_exp;
      idx_q[0] <= push_idx;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        exp_q[i] <= exp_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign tail_vld = vld_q[LATENCY-1];
  assign tail_exp = exp_q[LATENCY-1];
  assign tail_idx = idx_q[LATENCY-1];

endmodule

// File: rtl/and_gate_checker.sv
// Hardware monitor for a registered 2-input AND gate: compares s against a
// LATENCY-delayed a&b for num_samples cycles, counts matches/mismatches,
// records the first failing sample index and reports pass with a done pulse.
// Ports: clk/rst, start+num_samples (run request), a/b/s (gate under check),
// busy/done/pass/match_cnt/mismatch_cnt/first_err_idx (status).
module and_gate_checker
  import checker_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_samples,
  input  logic               a,
  input  logic               b,
  input  logic               s,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [COUNT_W-1:0] match_cnt,
  output logic [COUNT_W-1:0] mismatch_cnt,
  output logic [COUNT_W-1:0] first_err_idx
);

  localparam int               DRAIN_W    = $clog2(LATENCY_MAX + 1);
  localparam logic [COUNT_W-1:0] NO_ERR_IDX = NO_ERR_ALL_ONES[COUNT_W-1:0];
  localparam logic [COUNT_W-1:0] CNT_MAX    = NO_ERR_ALL_ONES[COUNT_W-1:0];
  localparam logic [COUNT_W-1:0] ONE        = COUNT_W'(1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(LATENCY - 1);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("and_gate_checker: LATENCY out of range 1..4");
  end

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   n_q, n_d;
  logic [COUNT_W-1:0]   idx_q, idx_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [COUNT_W-1:0]   match_q, match_d;
  logic [COUNT_W-1:0]   mism_q, mism_d;
  logic [COUNT_W-1:0]   ferr_q, ferr_d;
  logic                 pass_q, pass_d;

  logic                 start_acc;
  logic                 tail_vld, tail_exp;
  logic [COUNT_W-1:0]   tail_idx;

  assign start_acc = (state_q == ST_IDLE) && start;

  exp_delay_line #(
    .LATENCY(LATENCY),
    .IDX_W  (COUNT_W)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .push_vld(state_q == ST_RUN),
    .push_exp(a & b),
    .push_idx(idx_q),
    .tail_vld(tail_vld),
    .tail_exp(tail_exp),
    .tail_idx(tail_idx)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = (num_samples == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (idx_q == n_q - ONE) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q == LAST_DRAIN) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done = (state_q == ST_DONE);
  end

  // Datapath next state: compare runs in every state; an accepted start
  // overrides any (necessarily invalid) compare in the same cycle.
  always_comb begin
    n_d     = n_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    match_d = match_q;
    mism_d  = mism_q;
    ferr_d  = ferr_q;
    pass_d  = pass_q;

    if (tail_vld) begin
      if (tail_exp == s) begin
        if (match_q != CNT_MAX) match_d = match_q + ONE;
      end else begin
        if (mism_q != CNT_MAX) mism_d = mism_q + ONE;
        if (mism_q == '0)      ferr_d = tail_idx;
      end
    end

    if (state_q == ST_RUN)   idx_d   = idx_q + ONE;
    if (state_q == ST_RUN)   drain_d = '0;
    if (state_q == ST_DRAIN) drain_d = drain_q + DRAIN_W'(1);

    if (start_acc) begin
      n_d     = num_samples;
      idx_d   = '0;
      match_d = '0;
      mism_d  = '0;
      ferr_d  = NO_ERR_IDX;
      pass_d  = 1'b0;
    end

    // Resolve pass on entry to DONE so it is already valid while done is high;
    // mism_d includes the final compare landing on this same edge.
    if (state_q != ST_DONE && state_d == ST_DONE) pass_d = (mism_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q     <= '0;
      idx_q   <= '0;
      drain_q <= '0;
      match_q <= '0;
      mism_q  <= '0;
      ferr_q  <= NO_ERR_IDX;
      pass_q  <= 1'b0;
    end else begin
      n_q     <= n_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      match_q <= match_d;
      mism_q  <= mism_d;
      ferr_q  <= ferr_d;
      pass_q  <= pass_d;
    end
  end

  assign pass          = pass_q;
  assign match_cnt     = match_q;
  assign mismatch_cnt  = mism_q;
  assign first_err_idx = ferr_q;

endmodule

// File: tb/tb_and_gate_checker.sv
// Scoreboard bench: two checkers (LATENCY 1 and 3) watch a behavioural gate;
// expected end-of-run results are queued at stimulus time and popped on done.
module tb_and_gate_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_samples = '0;
  logic        a = 1'b0, b = 1'b0, inj = 1'b0, sel3 = 1'b1;
  logic [2:0]  pipe = '0;
  logic        s1, s3;

  logic        busy1, done1, pass1, busy3, done3, pass3;
  logic [15:0] m1, mm1, fe1, m3, mm3, fe3;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int m;
    int mm;
    int fe;
    int ps;
    int bz;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   bcnt1 = 0, bcnt3 = 0;

  always #5 clk = ~clk;

  // Gate model: registered AND with optional forced-high fault, 3 stages deep.
  always @(posedge clk) pipe <= {pipe[1:0], (a & b) | inj};
  assign s1 = pipe[0];
  assign s3 = sel3 ? pipe[2] : pipe[0];

  and_gate_checker #(.LATENCY(1), .COUNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .a(a), .b(b), .s(s1), .busy(busy1), .done(done1), .pass(pass1),
    .match_cnt(m1), .mismatch_cnt(mm1), .first_err_idx(fe1)
  );

  and_gate_checker #(.LATENCY(3), .COUNT_W(16)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .a(a), .b(b), .s(s3), .busy(busy3), .done(done3), .pass(pass3),
    .match_cnt(m3), .mismatch_cnt(mm3), .first_err_idx(fe3)
  );

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor for LATENCY=1 instance
  always @(negedge clk) begin
    if (rst) begin
      bcnt1 = 0;
    end else begin
      if (busy1) bcnt1++;
      if (done1) begin
        if (q1.size() == 0) begin
          chk("d1_unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk("d1_match", int'(m1), e.m);
          chk("d1_mismatch", int'(mm1), e.mm);
          chk("d1_first_err", int'(fe1), e.fe);
          chk("d1_pass", int'(pass1), e.ps);
          chk("d1_busy_cycles", bcnt1, e.bz);
          chk("d1_busy_at_done", int'(busy1), 0);
        end
        bcnt1 = 0;
      end
    end
  end

  // Monitor for LATENCY=3 instance
  always @(negedge clk) begin
    if (rst) begin
      bcnt3 = 0;
    end else begin
      if (busy3) bcnt3++;
      if (done3) begin
        if (q3.size() == 0) begin
          chk("d3_unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q3.pop_front();
          chk("d3_match", int'(m3), e.m);
          chk("d3_mismatch", int'(mm3), e.mm);
          chk("d3_first_err", int'(fe3), e.fe);
          chk("d3_pass", int'(pass3), e.ps);
          chk("d3_busy_cycles", bcnt3, e.bz);
          chk("d3_busy_at_done", int'(busy3), 0);
        end
        bcnt3 = 0;
      end
    end
  end

  function automatic exp_t mk(input int m, input int mm, input int fe, input int ps, input int bz);
    exp_t e;
    e.m = m; e.mm = mm; e.fe = fe; e.ps = ps; e.bz = bz;
    return e;
  endfunction

  // One run: pat holds {a,b} of sample i at bits [2i+1:2i]; inj_mask bit i
  // forces the gate output high for sample i; a second start (num=3) is
  // pulsed during sample xs when xs >= 0. stop_at >= 0 aborts via reset.
  task automatic run(input int n, input logic [31:0] pat, input logic [15:0] inj_mask,
                     input int xs, input int stop_at);
    @(negedge clk);
    start = 1'b1;
    num_samples = 16'(n);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == stop_at) break;
      {a, b} = pat[2*i +: 2];
      inj    = inj_mask[i];
      if (i == xs) begin
        start = 1'b1;
        num_samples = 16'd3;
      end else begin
        start = 1'b0;
        num_samples = 16'(n);
      end
      @(negedge clk);
    end
    start = 1'b0;
    a = 1'b0; b = 1'b0; inj = 1'b0;
    if (stop_at < 0) repeat (8) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy1"}, int'(busy1), 0);
    chk({tag, "_done1"}, int'(done1), 0);
    chk({tag, "_pass1"}, int'(pass1), 0);
    chk({tag, "_m1"}, int'(m1), 0);
    chk({tag, "_mm1"}, int'(mm1), 0);
    chk({tag, "_fe1"}, int'(fe1), 16'hFFFF);
    chk({tag, "_busy3"}, int'(busy3), 0);
    chk({tag, "_fe3"}, int'(fe3), 16'hFFFF);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // All match: walking 00,01,10,11 twice
    q1.push_back(mk(8, 0, 16'hFFFF, 1, 9));
    q3.push_back(mk(8, 0, 16'hFFFF, 1, 11));
    run(8, 32'h0000E4E4, 16'h0000, -1, -1);

    // Injected fault at samples 2 and 5 (both a=1,b=0)
    q1.push_back(mk(6, 2, 2, 0, 9));
    q3.push_back(mk(6, 2, 2, 0, 11));
    run(8, 32'h0000D8E4, 16'h0024, -1, -1);

    // Latency: matching 3-stage model on the LATENCY=3 checker
    q1.push_back(mk(5, 0, 16'hFFFF, 1, 6));
    q3.push_back(mk(5, 0, 16'hFFFF, 1, 8));
    run(5, 32'h00000373, 16'h0000, -1, -1);

    // Same stimulus, 1-stage model feeding the LATENCY=3 checker:
    // sample k is compared with sample k+2's result; only sample 4 differs.
    sel3 = 1'b0;
    q1.push_back(mk(5, 0, 16'hFFFF, 1, 6));
    q3.push_back(mk(4, 1, 4, 0, 8));
    run(5, 32'h00000373, 16'h0000, -1, -1);
    sel3 = 1'b1;

    // Zero-length run
    q1.push_back(mk(0, 0, 16'hFFFF, 1, 0));
    q3.push_back(mk(0, 0, 16'hFFFF, 1, 0));
    run(0, 32'h0, 16'h0, -1, -1);

    // Reset mid-run at sample 4 of 10: no expectation queued, so any done fails
    run(10, 32'h000E4E4E, 16'h0000, -1, 4);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrun");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Clean run after the abort
    q1.push_back(mk(8, 0, 16'hFFFF, 1, 9));
    q3.push_back(mk(8, 0, 16'hFFFF, 1, 11));
    run(8, 32'h0000E4E4, 16'h0000, -1, -1);

    // Start while busy: second start with num=3 is ignored
    q1.push_back(mk(6, 0, 16'hFFFF, 1, 7));
    q3.push_back(mk(6, 0, 16'hFFFF, 1, 9));
    run(6, 32'h0000E4E4, 16'h0000, 2, -1);

    chk("q1_left", q1.size(), 0);
    chk("q3_left", q3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/and_gate_checker.md
# and_gate_checker

Synthesizable self-checking monitor for the registered two-input AND gate. It consumes the gate's inputs and output and compares `s` against a delayed copy of `a & b`. It also counts matches and mismatches and reports pass/fail when a run ends. The block sits beside the gate in on-board test builds, so stimulus from a generator or from switches is checked in hardware rather than only in simulation.

## Interface
- `LATENCY`, 1: clock cycles from `a`/`b` sampled to `s` valid, legal range 1..4.
- `COUNT_W`, 16: width of the sample-count input and of every counter output.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge system clock (50 MHz nominal).
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle run request; honoured only in IDLE.
- `num_samples`  in  COUNT_W  samples to check; latched on accepted `start`.
- `a`  in  1  gate input a, same wire that drives the gate.
- `b`  in  1  gate input b.
- `s`  in  1  gate output under check.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  high when the last run had zero mismatches; held until next accepted `start`.
- `match_cnt`  out  COUNT_W  matched samples in current/last run.
- `mismatch_cnt`  out  COUNT_W  mismatched samples in current/last run.
- `first_err_idx`  out  COUNT_W  index of first mismatched sample; all-ones if none.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE:** waits for `start`.
  - On `start`, latch `num_samples` and clear counters. Set `first_err_idx` to all-ones and `pass` to 0.
  - If `num_samples == 0`, go to DONE. Otherwise go to RUN.
- **RUN:** each cycle, push `{valid=1, exp=a&b, idx}` into a LATENCY-deep shift register. `idx` counts from 0.
  - After `num_samples` pushes, go to DRAIN. Pushes then carry valid=0.
- **DRAIN:** lasts exactly LATENCY cycles, then go to DONE.
- **DONE:** one cycle. Pulse `done`, set `pass = (mismatch_cnt == 0)`, return to IDLE.
- **Comparison:** active in every state. When the pipeline tail has valid=1, compare tail `exp` with `s`.
  - Equal: `match_cnt` +1.
  - Different: `mismatch_cnt` +1. If this is the first mismatch, `first_err_idx` takes the tail `idx`.
- **Counter saturation:** counters saturate at all-ones and never wrap.
- **`start` while not IDLE:** ignored, with no effect on the latched count.
- **`a`/`b` outside RUN:** ignored (valid=0).

## Timing
- **Reset values:** all outputs are 0 except `first_err_idx`, which is all-ones. State is IDLE and the pipeline valid bits are 0.
- **Reset mid-run:** aborts immediately (asynchronous). No `done` pulse follows.
- **Start to busy:** `start` sampled at edge 0 → `busy` high after edge 0. The first sample is taken at edge 1.
- **Sample to compare:** sample taken at edge k is compared at edge k+LATENCY.
- **Run length:** N samples → `busy` high for N+LATENCY cycles. `done` is high for the single cycle after `busy` falls.
- **Outputs after the run:** `pass` and the counters are final when `done` is high, and hold until the next accepted `start`.
- **Same-cycle `start` and `done`:** `start` asserted in the DONE cycle is ignored. It is only accepted from IDLE, one cycle later.
- **Timing assumption:** `a`/`b` change away from active edges; there is no synchronizer. Inputs from switches must be synchronized upstream.

## Structure
- Shared package `checker_pkg` holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3);
  - the `LATENCY` range limits;
  - the all-ones "no error" constant.
- One sub-module, `exp_delay_line`, is the LATENCY-deep `{valid, exp, idx}` shift register. The FSM, counters and compare logic stay in the top.

## Test plan
- **All match:** gate model correct, LATENCY=1, N=8, a/b walking 00,01,10,11 twice → `done` one cycle after `busy` falls. `match_cnt` = 8, `mismatch_cnt` = 0, `pass` = 1, `first_err_idx` = 16'hFFFF.
- **Injected fault:** model forces `s` high when input was a=1, b=0 at samples 2 and 5, N=8 → `mismatch_cnt` = 2, `match_cnt` = 6, `first_err_idx` = 2, `pass` = 0.
- **Latency change:** LATENCY=3 with a matching 3-stage gate model, N=5 → `busy` high 8 cycles, `pass` = 1. The same stimulus with a 1-stage model gives `pass` = 0.
- **Zero-length run:** `num_samples` = 0 → `busy` never high, `done` pulses at edge 1, `pass` = 1, counters 0.
- **Reset mid-run:** assert `rst` mid-RUN at sample 4 of N=10 → all outputs return to reset values immediately and no `done` pulse follows. A new `start` then runs cleanly.
- **Start while busy:** pulse `start` with `num_samples` = 3 during RUN of N=6 → run still checks 6 samples. The second `start` is ignored.
